shop_order_ctrl: RTL



---
 rtl/shop_order_if.sv | 44 ++++
 rtl/shop_order_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/shop_order_if.sv
// Order controller bus bundle: the order handshake, the supplier restock channels
// and the result strobe with its bill digits.
//   in_valid/in_ready/order_qty     : order handshake, product i at [i*QTY_W +: QTY_W]
//   sup_valid/sup_ready             : one restock valid/ready pair per supplier
//   sup_prod/sup_num                : product being restocked and the units requested
//   out_valid/total/ten/five/one    : one-cycle result strobe and the bill split into change digits
//   run_out_ing                     : set with out_valid when the order needed a restock
// The slave modport is the controller's view; the master modport is the view of
// whatever places orders and serves suppliers.
interface shop_order_if #(
  parameter int NUM_PROD = 4,
  parameter int QTY_W    = 3,
  parameter int STOCK_W  = 7,
  parameter int NUM_SUP  = 2,
  parameter int TOT_W    = 8
);
  localparam int PROD_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_PROD*QTY_W-1:0] order_qty;
  logic [NUM_SUP-1:0]        sup_valid;
  logic [NUM_SUP-1:0]        sup_ready;
  logic [PROD_W-1:0]         sup_prod;
  logic [STOCK_W-1:0]        sup_num;
  logic                      out_valid;
  logic [TOT_W-1:0]          total;
  logic [TOT_W-1:0]          ten;
  logic                      five;
  logic [2:0]                one;
  logic                      run_out_ing;

  modport slave (
    input  in_valid, order_qty, sup_ready,
    output in_ready, sup_valid, sup_prod, sup_num,
           out_valid, total, ten, five, one, run_out_ing
  );

  modport master (
    output in_valid, order_qty, sup_ready,
    input  in_ready, sup_valid, sup_prod, sup_num,
           out_valid, total, ten, five, one, run_out_ing
  );
endinterface

// File: rtl/shop_order_ctrl.sv
// Shop order controller. It takes one order at a time and restocks every short
// product to STOCK_MAX, lowest index first, through the supplier that serves it.
// It then deducts the order from stock and strobes the bill with its ten/five/one
// change digits.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset; an operation in progress is abandoned
//   bus    : shop_order_if.slave (order handshake, supplier channels, result strobe)
// Every output is a register, so in_valid and sup_ready have no combinational path
// to any output.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an order
// CHECK | look for the lowest-index product whose stock is below its ordered qty
// REQ   | restock request held on the selected supplier until sup_ready
// DONE  | deduct the order; result strobe is high for this cycle
module shop_order_ctrl #(
  parameter int NUM_PROD  = 4,
  parameter int QTY_W     = 3,
  parameter int STOCK_MAX = 50,
  parameter int STOCK_W   = 7,
  parameter int PRICE_W   = 4,
  parameter logic [NUM_PROD*PRICE_W-1:0] PRICES = {4'd4, 4'd2, 4'd5, 4'd3},
  parameter int NUM_SUP   = 2,
  parameter logic [NUM_PROD*((NUM_SUP > 1) ? $clog2(NUM_SUP) : 1)-1:0] SUP_SEL = 4'b1100,
  parameter int TOT_W     = 8
) (
  input logic         clk,
  input logic         rst_n,
  shop_order_if.slave bus
);
  localparam int PROD_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
  localparam int SEL_W  = (NUM_SUP > 1) ? $clog2(NUM_SUP) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} state_t;

  state_t                    state;
  logic [NUM_PROD*QTY_W-1:0] qty_q;
  logic [STOCK_W-1:0]        stock [NUM_PROD];
  logic [PROD_W-1:0]         cur;
  logic                      restocked;

  logic                      found;
  logic [PROD_W-1:0]         found_idx;
  logic [SEL_W-1:0]          found_sup;
  logic [31:0]               acc;
  logic [TOT_W-1:0]          bill;
  logic [TOT_W-1:0]          rem10;

  // The loop runs from high to low index, so the lowest short product is the one left selected.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    found_sup = '0;
    for (int i = NUM_PROD - 1; i >= 0; i--) begin
      if (stock[i] < STOCK_W'(qty_q[i*QTY_W +: QTY_W])) begin
        found     = 1'b1;
        found_idx = PROD_W'(i);
        found_sup = SUP_SEL[i*SEL_W +: SEL_W];
      end
    end
  end

  // The bill is accumulated at 32 bits and then truncated to TOT_W.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      acc = acc + 32'(qty_q[i*QTY_W +: QTY_W]) * 32'(PRICES[i*PRICE_W +: PRICE_W]);
    end
    bill = TOT_W'(acc);
  end

  assign rem10 = bill % TOT_W'(10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      qty_q           <= '0;
      cur             <= '0;
      restocked       <= 1'b0;
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= '0;
      bus.in_ready    <= 1'b1;
      bus.sup_valid   <= '0;
      bus.sup_prod    <= '0;
      bus.sup_num     <= '0;
      bus.out_valid   <= 1'b0;
      bus.total       <= '0;
      bus.ten         <= '0;
      bus.five        <= 1'b0;
      bus.one         <= '0;
      bus.run_out_ing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            qty_q        <= bus.order_qty;
            restocked    <= 1'b0;
            bus.in_ready <= 1'b0;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (found) begin
            cur           <= found_idx;
            bus.sup_valid <= NUM_SUP'(1) << found_sup;
            bus.sup_prod  <= found_idx;
            bus.sup_num   <= STOCK_W'(STOCK_MAX) - stock[found_idx];
            state         <= REQ;
          end else begin
            bus.out_valid   <= 1'b1;
            bus.total       <= bill;
            bus.ten         <= bill / TOT_W'(10);
            bus.five        <= (rem10 >= TOT_W'(5));
            bus.one         <= 3'(bill % TOT_W'(5));
            bus.run_out_ing <= restocked;
            state           <= DONE;
          end
        end
        REQ: begin
          // Only the selected supplier's sup_valid bit is set, so the AND picks out its handshake alone.
          if ((bus.sup_valid & bus.sup_ready) != '0) begin
            stock[cur]    <= STOCK_W'(STOCK_MAX);
            restocked     <= 1'b1;
            bus.sup_valid <= '0;
            bus.sup_prod  <= '0;
            bus.sup_num   <= '0;
            state         <= CHECK;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_PROD; i++) begin
            stock[i] <= stock[i] - STOCK_W'(qty_q[i*QTY_W +: QTY_W]);
          end
          bus.out_valid   <= 1'b0;
          bus.total       <= '0;
          bus.ten         <= '0;
          bus.five        <= 1'b0;
          bus.one         <= '0;
          bus.run_out_ing <= 1'b0;
          bus.in_ready    <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
